carry_event_counter: RTL and testbench

CARRY_EVENT_COUNTER -- requirements
Module: carry_event_counter

---
 rtl/carry_event_counter.sv | 116 +++++++++++
 tb/tb_carry_event_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/carry_event_counter.sv
// Counts rising edges of an upstream 4-bit counter's carry, with a threshold alarm,
// a sticky wrap flag and a capture/acknowledge snapshot of {ovf_count, cnt_in}.
module carry_event_counter #(
  parameter int unsigned OVF_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [0:3]       cnt_in,
  input  logic             carry_in,
  input  logic             enable,
  input  logic             thr_load,
  input  logic [0:OVF_W-1] thr_in,
  input  logic             capture,
  input  logic             ack,
  output logic [0:OVF_W-1] ovf_count,
  output logic [0:OVF_W+3] snap,
  output logic             snap_valid,
  output logic             alarm,
  output logic             ovf_wrap
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SNAP_W = OVF_W + CNT_W;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_snap_load;

  logic [CNT_W-1:0]  w_cnt;
  logic [OVF_W-1:0]  w_thr;
  logic [OVF_W-1:0]  r_ovf;
  logic [OVF_W-1:0]  r_thr;
  logic [OVF_W-1:0]  w_ovf_inc;
  logic [SNAP_W-1:0] r_snap;
  logic              r_carry_d;
  logic              r_alarm;
  logic              r_wrap;
  logic              r_snap_valid;
  logic              w_event;

  // Ascending-range ports carry the LSB at index 0; map them onto numeric vectors.
  always_comb begin
    for (int i = 0; i < CNT_W; i++) w_cnt[i] = cnt_in[i];
    for (int i = 0; i < OVF_W; i++) w_thr[i] = thr_in[i];
    for (int i = 0; i < OVF_W; i++) ovf_count[i] = r_ovf[i];
    for (int i = 0; i < SNAP_W; i++) snap[i] = r_snap[i];
  end

  assign snap_valid = r_snap_valid;
  assign alarm      = r_alarm;
  assign ovf_wrap   = r_wrap;

  assign w_event   = carry_in & ~r_carry_d & enable;
  assign w_ovf_inc = r_ovf + OVF_W'(1);

  // Event counter, threshold alarm and wrap flag.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_carry_d <= 1'b0;
      r_ovf     <= '0;
      r_thr     <= '0;
      r_alarm   <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_carry_d <= carry_in;
      if (w_event) begin
        r_ovf <= w_ovf_inc;
        if (r_ovf == OVF_MAX) r_wrap <= 1'b1;
      end
      if (thr_load) begin
        r_thr   <= w_thr;
        r_alarm <= 1'b0;
      end else if (w_event && (r_thr != '0) && (w_ovf_inc == r_thr)) begin
        r_alarm <= 1'b1;
      end
    end
  end

  // Capture FSM state and snapshot registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state      <= S_IDLE;
      r_snap_valid <= 1'b0;
      r_snap       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_snap_valid <= (w_state_nxt == S_HOLD);
      if (w_snap_load) r_snap <= {r_ovf, w_cnt};
    end
  end

  // Capture only from IDLE; ack releases HOLD even when capture is also high.
  always_comb begin
    w_state_nxt = r_state;
    w_snap_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (capture) begin
          w_state_nxt = S_HOLD;
          w_snap_load = 1'b1;
        end
      end
      S_HOLD: begin
        if (ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_carry_event_counter.sv
// Directed, table-driven bench for carry_event_counter (OVF_W = 8).
module tb_carry_event_counter;

  localparam int unsigned OVF_W = 8;

  logic             clock = 1'b0;
  logic             clear, carry_in, enable, thr_load, capture, ack;
  logic [0:3]       cnt_in;
  logic [0:OVF_W-1] thr_in;
  logic [0:OVF_W-1] ovf_count;
  logic [0:OVF_W+3] snap;
  logic             snap_valid, alarm, ovf_wrap;

  logic [3:0]       v_cnt;
  logic [7:0]       v_thr;
  logic [7:0]       m_ovf;
  logic [11:0]      m_snap;

  int n_checks = 0;
  int n_err    = 0;

  carry_event_counter #(.OVF_W(OVF_W)) dut (
    .clock(clock), .clear(clear), .cnt_in(cnt_in), .carry_in(carry_in),
    .enable(enable), .thr_load(thr_load), .thr_in(thr_in), .capture(capture),
    .ack(ack), .ovf_count(ovf_count), .snap(snap), .snap_valid(snap_valid),
    .alarm(alarm), .ovf_wrap(ovf_wrap)
  );

  always #5 clock = ~clock;

  // Index 0 of every ascending-range port is the numeric LSB.
  always_comb begin
    for (int i = 0; i < 4; i++) cnt_in[i] = v_cnt[i];
    for (int i = 0; i < 8; i++) thr_in[i] = v_thr[i];
    for (int i = 0; i < 8; i++) m_ovf[i] = ovf_count[i];
    for (int i = 0; i < 12; i++) m_snap[i] = snap[i];
  end

  typedef struct {
    logic       clr, en, cy, cap, ack, tl;
    logic [7:0] thr;
    logic [3:0] cnt;
    logic [7:0] e_ovf;
    logic [11:0] e_snap;
    logic       e_sv, e_al, e_wr;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; enable = 0; carry_in = 0; capture = 0; ack = 0; thr_load = 0;
    v_thr = '0; v_cnt = '0;
  endtask

  task automatic pulse();
    carry_in = 1; step();
    carry_in = 0; step();
  endtask

  task automatic do_clear();
    idle_inputs();
    clear = 1; step();
    clear = 0;
  endtask

  task automatic chk_all(input string name, input int idx, input logic [7:0] e_ovf,
                         input logic [11:0] e_snap, input logic e_sv, input logic e_al,
                         input logic e_wr);
    chk({name, ".ovf"},  idx, 32'(m_ovf),      32'(e_ovf));
    chk({name, ".snap"}, idx, 32'(m_snap),     32'(e_snap));
    chk({name, ".sv"},   idx, 32'(snap_valid), 32'(e_sv));
    chk({name, ".al"},   idx, 32'(alarm),      32'(e_al));
    chk({name, ".wr"},   idx, 32'(ovf_wrap),   32'(e_wr));
  endtask

  initial begin
    //           clr en cy cap ack tl thr   cnt    ovf    snap     sv al wr
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 8'd0, 4'd0,  8'd0, 12'h000, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 1, 0, 1, 8'd5, 4'd7,  8'd0, 12'h000, 0, 0, 0};
    vecs[2]  = '{0, 1, 1, 0, 0, 0, 8'd0, 4'd0,  8'd1, 12'h000, 0, 0, 0};
    vecs[3]  = '{0, 1, 1, 0, 0, 0, 8'd0, 4'd0,  8'd1, 12'h000, 0, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 0, 8'd0, 4'd0,  8'd1, 12'h000, 0, 0, 0};
    vecs[5]  = '{0, 0, 1, 0, 0, 0, 8'd0, 4'd0,  8'd1, 12'h000, 0, 0, 0};
    vecs[6]  = '{0, 1, 1, 0, 0, 0, 8'd0, 4'd0,  8'd1, 12'h000, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0, 8'd0, 4'd0,  8'd1, 12'h000, 0, 0, 0};
    vecs[8]  = '{0, 1, 1, 0, 0, 1, 8'd3, 4'd0,  8'd2, 12'h000, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 0, 8'd0, 4'd0,  8'd2, 12'h000, 0, 0, 0};
    vecs[10] = '{0, 1, 1, 1, 0, 0, 8'd0, 4'd15, 8'd3, 12'h02F, 1, 1, 0};
    vecs[11] = '{0, 1, 0, 1, 0, 0, 8'd0, 4'd4,  8'd3, 12'h02F, 1, 1, 0};
    vecs[12] = '{0, 1, 0, 1, 1, 0, 8'd0, 4'd4,  8'd3, 12'h02F, 0, 1, 0};
    vecs[13] = '{0, 1, 0, 0, 1, 0, 8'd0, 4'd4,  8'd3, 12'h02F, 0, 1, 0};
    vecs[14] = '{0, 1, 0, 0, 0, 1, 8'd10, 4'd0, 8'd3, 12'h02F, 0, 0, 0};
    vecs[15] = '{0, 1, 0, 1, 0, 0, 8'd0, 4'd1,  8'd3, 12'h031, 1, 0, 0};
    vecs[16] = '{0, 1, 1, 0, 0, 1, 8'd4, 4'd0,  8'd4, 12'h031, 1, 0, 0};
    vecs[17] = '{0, 1, 0, 0, 0, 0, 8'd0, 4'd0,  8'd4, 12'h031, 1, 0, 0};
    vecs[18] = '{1, 1, 0, 0, 0, 0, 8'd0, 4'd0,  8'd0, 12'h000, 0, 0, 0};
    vecs[19] = '{0, 0, 1, 0, 0, 0, 8'd0, 4'd0,  8'd0, 12'h000, 0, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 0, 8'd0, 4'd0,  8'd0, 12'h000, 0, 0, 0};

    idle_inputs();
    @(negedge clock);

    foreach (vecs[i]) begin
      clear = vecs[i].clr; enable = vecs[i].en; carry_in = vecs[i].cy;
      capture = vecs[i].cap; ack = vecs[i].ack; thr_load = vecs[i].tl;
      v_thr = vecs[i].thr; v_cnt = vecs[i].cnt;
      step();
      chk_all("vec", i, vecs[i].e_ovf, vecs[i].e_snap, vecs[i].e_sv,
              vecs[i].e_al, vecs[i].e_wr);
    end

    // Periodic single-cycle carries, then one long carry.
    do_clear();
    enable = 1;
    for (int p = 0; p < 5; p++) begin
      carry_in = 1; step();
      carry_in = 0; repeat (15) step();
    end
    chk("count5", 0, 32'(m_ovf), 32'd5);
    carry_in = 1; repeat (4) step();
    carry_in = 0; step();
    chk("held4", 0, 32'(m_ovf), 32'd6);

    // Threshold alarm and reload.
    do_clear();
    enable = 1;
    thr_load = 1; v_thr = 8'd3; step();
    thr_load = 0;
    pulse(); pulse();
    chk("thr.pre", 0, 32'(alarm), 32'd0);
    carry_in = 1; step();
    chk("thr.hit", 0, 32'(alarm), 32'd1);
    chk("thr.ovf", 0, 32'(m_ovf), 32'd3);
    carry_in = 0; step();
    thr_load = 1; v_thr = 8'd10; step();
    thr_load = 0;
    chk("thr.reload", 0, 32'(alarm), 32'd0);
    chk("thr.keep", 0, 32'(m_ovf), 32'd3);

    // Clear while holding a snapshot with alarm set.
    thr_load = 1; v_thr = 8'd4; step();
    thr_load = 0;
    pulse();
    v_cnt = 4'd2; capture = 1; step();
    capture = 0;
    chk("rst.sv_pre", 0, 32'(snap_valid), 32'd1);
    chk("rst.al_pre", 0, 32'(alarm), 32'd1);
    chk("rst.snap_pre", 0, 32'(m_snap), 32'h042);
    clear = 1; step();
    clear = 0;
    chk_all("rst", 0, 8'd0, 12'h000, 1'b0, 1'b0, 1'b0);
    enable = 0;
    pulse(); pulse(); pulse();
    chk("rst.en0", 0, 32'(m_ovf), 32'd0);

    // Wrap of the event counter.
    do_clear();
    enable = 1;
    for (int p = 0; p < 255; p++) pulse();
    chk("wrap.255", 0, 32'(m_ovf), 32'd255);
    chk("wrap.pre", 0, 32'(ovf_wrap), 32'd0);
    pulse();
    chk("wrap.0", 0, 32'(m_ovf), 32'd0);
    chk("wrap.set", 0, 32'(ovf_wrap), 32'd1);
    pulse();
    chk("wrap.1", 0, 32'(m_ovf), 32'd1);
    chk("wrap.stay", 0, 32'(ovf_wrap), 32'd1);

    // Capture held until ack while counting continues.
    do_clear();
    enable = 1;
    repeat (7) pulse();
    v_cnt = 4'd9; capture = 1; step();
    chk("cap.snap", 0, 32'(m_snap), 32'h079);
    chk("cap.sv", 0, 32'(snap_valid), 32'd1);
    v_cnt = 4'd3;
    pulse(); pulse();
    chk("cap.hold", 0, 32'(m_snap), 32'h079);
    chk("cap.ovf", 0, 32'(m_ovf), 32'd9);
    capture = 0; ack = 1; step();
    ack = 0;
    chk("cap.ack", 0, 32'(snap_valid), 32'd0);
    chk("cap.keep", 0, 32'(m_snap), 32'h079);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
